alu_arbiter: RTL and testbench

//   Shares one combinational alu (AND/OR/ADD/SUB/SLT) between N_REQ requesters.

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu.sv | 46 ++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: data width, ALUop encodings,
// response FSM states and the registered response bundle.
package alu_arbiter_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  overflow;
        logic                  carry_out;
    } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT. Undefined opcodes yield Result=0, Zero=1.
// For SUB, CarryOut reports an unsigned borrow (A < B).
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALUop,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero,
    output logic                  Overflow,
    output logic                  CarryOut
);

    logic [DATA_WIDTH:0] w_sum;

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        w_sum    = '0;
        Result   = '0;
        Overflow = 1'b0;
        CarryOut = 1'b0;
        case (ALUop)
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_ADD: begin
                w_sum    = {1'b0, A} + {1'b0, B};
                Result   = w_sum[DATA_WIDTH-1:0];
                CarryOut = w_sum[DATA_WIDTH];
                Overflow = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                           (Result[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            ALU_SUB: begin
                w_sum    = {1'b0, A} - {1'b0, B};
                Result   = w_sum[DATA_WIDTH-1:0];
                CarryOut = w_sum[DATA_WIDTH];
                Overflow = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                           (Result[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
            end
            ALU_SLT: Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
        Zero = (Result == '0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after i_ptr (wrapping),
// returned both one-hot and as an index. Nothing is granted when i_en is low.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    input  logic             i_en,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (i_en && !o_any && i_req[(int'(i_ptr) + k) % N_REQ]) begin
                o_any                               = 1'b1;
                o_gnt[(int'(i_ptr) + k) % N_REQ]    = 1'b1;
                o_idx                               = IDW'((int'(i_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin grant and a one-entry
// registered response. Optional statistics counters under ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_A,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_B,
    input  logic [N_REQ*3-1:0]          req_ALUop,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]       rsp_Result,
    output logic                        rsp_Zero,
    output logic                        rsp_Overflow,
    output logic                        rsp_CarryOut
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]                 stat_grants,
    output logic [31:0]                 stat_stalls
`endif
);

    rsp_state_e            r_state;
    rsp_state_e            w_state_nxt;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        r_rsp_id;
    alu_rsp_t              r_rsp;
    alu_rsp_t              w_alu_rsp;
    logic                  w_can_accept;
    logic                  w_grant;
    logic [N_REQ-1:0]      w_gnt;
    logic [IDW-1:0]        w_gnt_idx;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [2:0]            w_op;

    assign w_can_accept = !rst && ((r_state == ST_EMPTY) || rsp_ready);

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .i_en  (w_can_accept),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_grant)
    );

    // One-hot grant makes an AND-OR mux sufficient.
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_a  = req_A[i*DATA_WIDTH +: DATA_WIDTH];
                w_b  = req_B[i*DATA_WIDTH +: DATA_WIDTH];
                w_op = req_ALUop[i*3 +: 3];
            end
        end
    end

    alu u_alu (
        .A        (w_a),
        .B        (w_b),
        .ALUop    (w_op),
        .Result   (w_alu_rsp.result),
        .Zero     (w_alu_rsp.zero),
        .Overflow (w_alu_rsp.overflow),
        .CarryOut (w_alu_rsp.carry_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
            ST_FULL:  if (rsp_ready && !w_grant) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_ptr    <= '0;
            r_rsp_id <= '0;
            r_rsp    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_ptr    <= (w_gnt_idx == IDW'(N_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
                r_rsp_id <= w_gnt_idx;
                r_rsp    <= w_alu_rsp;
            end
        end
    end

    assign req_ready    = w_gnt;
    assign rsp_valid    = (r_state == ST_FULL);
    assign rsp_id       = r_rsp_id;
    assign rsp_Result   = r_rsp.result;
    assign rsp_Zero     = r_rsp.zero;
    assign rsp_Overflow = r_rsp.overflow;
    assign rsp_CarryOut = r_rsp.carry_out;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] r_stat_grants;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_grants <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_grant)
                r_stat_grants <= r_stat_grants + 32'd1;
            if ((r_state == ST_FULL) && !rsp_ready)
                r_stat_stalls <= r_stat_stalls + 32'd1;
        end
    end

    assign stat_grants = r_stat_grants;
    assign stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference grant/ALU model pushes expected
// responses on grant and compares them while the DUT holds its response.
module tb_alu_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*32-1:0] req_A;
    logic [N*32-1:0] req_B;
    logic [N*3-1:0]  req_ALUop;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_Result;
    logic          rsp_Zero;
    logic          rsp_Overflow;
    logic          rsp_CarryOut;
`ifdef ALU_ARB_STATS_EN
    logic [31:0]   stat_grants;
    logic [31:0]   stat_stalls;
    logic [31:0]   m_grants;
    logic [31:0]   m_stalls;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   sb[$];
    bit     m_full;
    int     m_ptr;
    logic [N-1:0] last_ready;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .IDW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_A        (req_A),
        .req_B        (req_B),
        .req_ALUop    (req_ALUop),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_Result   (rsp_Result),
        .rsp_Zero     (rsp_Zero),
        .rsp_Overflow (rsp_Overflow),
        .rsp_CarryOut (rsp_CarryOut)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grants  (stat_grants),
        .stat_stalls  (stat_stalls)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t        e;
        logic [32:0] w;
        e.id  = 2'(id);
        e.res = '0;
        e.o   = 1'b0;
        e.c   = 1'b0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: begin
                w     = {1'b0, a} + {1'b0, b};
                e.res = w[31:0];
                e.c   = w[32];
                e.o   = (a[31] & b[31] & ~w[31]) | (~a[31] & ~b[31] & w[31]);
            end
            3'b110: begin
                e.res = a - b;
                e.c   = (a < b);
                e.o   = (a[31] & ~b[31] & ~e.res[31]) | (~a[31] & b[31] & e.res[31]);
            end
            3'b111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
        req_A[i*32 +: 32]  = a;
        req_B[i*32 +: 32]  = b;
        req_ALUop[i*3 +: 3] = op;
    endtask

    // One clock: compare at the falling edge, advance the model after the rising edge.
    task automatic step();
        logic [N-1:0] eg;
        int           gi;
        bit           can;
        exp_t         e;
        exp_t         e_new;
        @(negedge clk);
        can = !rst && (!m_full || rsp_ready);
        eg  = '0;
        gi  = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                if (gi < 0 && req_valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            end
        end
        if (gi >= 0) begin
            eg[gi] = 1'b1;
            e_new  = model(gi, req_A[gi*32 +: 32], req_B[gi*32 +: 32], req_ALUop[gi*3 +: 3]);
        end
        last_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(eg));
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check("sb_depth", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb[0];
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_Result", rsp_Result, e.res);
                check("rsp_Zero", 32'(rsp_Zero), 32'(e.z));
                check("rsp_Overflow", 32'(rsp_Overflow), 32'(e.o));
                check("rsp_CarryOut", 32'(rsp_CarryOut), 32'(e.c));
            end
        end
`ifdef ALU_ARB_STATS_EN
        check("stat_grants", stat_grants, m_grants);
        check("stat_stalls", stat_stalls, m_stalls);
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb.delete();
`ifdef ALU_ARB_STATS_EN
            m_grants = '0;
            m_stalls = '0;
`endif
        end else begin
`ifdef ALU_ARB_STATS_EN
            if (gi >= 0) m_grants = m_grants + 32'd1;
            if (m_full && !rsp_ready) m_stalls = m_stalls + 32'd1;
`endif
            if (m_full && rsp_ready && sb.size() > 0) void'(sb.pop_front());
            if (gi >= 0) begin
                sb.push_back(e_new);
                m_ptr  = (gi == N - 1) ? 0 : gi + 1;
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    endtask

    initial begin
        m_full     = 1'b0;
        m_ptr      = 0;
        last_ready = '0;
`ifdef ALU_ARB_STATS_EN
        m_grants = '0;
        m_stalls = '0;
`endif
        rst       = 1'b1;
        req_valid = '1;
        req_A     = '0;
        req_B     = '0;
        req_ALUop = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with every requester valid: nothing granted, outputs cleared.
        repeat (2) step();
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_result", rsp_Result, 32'd0);
        check("rst_flags", {29'd0, rsp_Zero, rsp_Overflow, rsp_CarryOut}, 32'd0);

        // Single signed-overflowing ADD from requester 0.
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010);
        step();
        req_valid = '0;
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_result", rsp_Result, 32'h8000_0000);
        check("add_ovf_carry", {30'd0, rsp_Overflow, rsp_CarryOut}, 32'h2);
        step();

        // All requesters valid continuously: strict rotation, one op per cycle.
        set_req(0, $urandom, $urandom, 3'b111);
        set_req(1, $urandom, $urandom, 3'b001);
        set_req(2, $urandom, $urandom, 3'b110);
        set_req(3, $urandom, $urandom, 3'b011);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (12) step();
        req_valid = '0;
        step();

        // Backpressure on a SUB 5-5 with other requesters waiting.
        req_valid = 4'b0100;
        set_req(2, 32'd5, 32'd5, 3'b110);
        step();
        rsp_ready = 1'b0;
        set_req(0, 32'hFFFF_0000, 32'h0000_FFFF, 3'b000);
        set_req(1, 32'h1234_5678, 32'h8765_4321, 3'b010);
        req_valid = 4'b0011;
        repeat (5) step();
        check("bp_zero", 32'(rsp_Zero), 32'd1);
        rsp_ready = 1'b1;
        step();
        check("bp_regrant", 32'(last_ready), 32'b0001);
        req_valid = '0;
        repeat (2) step();

        // Pointer wrap: reach ptr=3, then only requester 1 asks for SLT.
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0010;
        set_req(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111);
        step();
        check("slt_grant", 32'(last_ready), 32'b0010);
        req_valid = '0;
        check("slt_result", rsp_Result, 32'd1);
        step();
        req_valid = 4'b1111;
        step();
        check("ptr_after_wrap", 32'(last_ready), 32'b0100);

        // Reset while holding a stalled response.
        rsp_ready = 1'b0;
        req_valid = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 4'b1111;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
`ifdef ALU_ARB_STATS_EN
        check("midrst_stat_grants", stat_grants, 32'd0);
        check("midrst_stat_stalls", stat_stalls, 32'd0);
`endif
        rsp_ready = 1'b1;
        step();
        check("midrst_grant0", 32'(last_ready), 32'b0001);
        req_valid = '0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
